// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   state_t    : FSM encoding (IDLE = no word in flight, SHIFT = bits in flight)
//   cnt_width  : width of the "bits remaining" counter for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The counter holds values 0..width-1, so $clog2(width) bits suffice.
  // Clamp to 1 so a degenerate width never produces a zero-width vector.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_if.sv
// Load handshake and serial output bundle of the serializer.
//   load_valid / load_ready / din : parallel word handshake (source -> serializer)
//   sout / sout_valid / sout_last : serial bit stream (serializer -> receiver)
//   busy                          : a word is in transmission
// Modports:
//   master : the word source / bit sink side
//   slave  : the serializer itself
interface piso_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output load_valid,
    output din,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  din,
    output load_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag, used to count the bits of a word
// that remain after the one currently on the serial line.
//   clk, rst  : clock and synchronous active-high reset (clears the count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero rather than wrapping
//   cnt       : current count
//   zero      : cnt == 0
module piso_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. A WIDTH-bit word accepted over the
// valid/ready load handshake is sent one bit per clock on sout, each bit
// qualified by sout_valid and the final bit flagged by sout_last. A new word
// can be accepted while the last bit of the previous one is on the line, so
// back-to-back words stream without a bubble.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : piso_if slave modport
//          load_valid, din  -> word offered by the source
//          load_ready       <- combinational, word can be accepted this cycle
//          sout, sout_valid, sout_last, busy <- registered serial side
// Parameters:
//   WIDTH     : word width (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 goes first, 0 = bit 0 goes first
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic  clk,
  input logic  rst,
  piso_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;

  // Bit that leaves first when a word is loaded.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word as stored after its first bit has been sent; the next bit to send
  // always sits at the outgoing end of the register.
  function automatic logic [WIDTH-1:0] after_first(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic next_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  // Ready in IDLE, or in SHIFT while the final bit is on the line; reset
  // overrides so a word offered during reset is never taken.
  assign bus.load_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_zero));
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.sout_last  = last_q;
  assign bus.busy       = busy_q;

  piso_bit_counter #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(WIDTH - 1)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    sout_d   = sout_q;
    vld_d    = vld_q;
    last_d   = last_q;
    busy_d   = busy_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        if (!cnt_zero) begin
          sout_d  = next_bit(sh_q);
          sh_d    = shift_out(sh_q);
          last_d  = (cnt == CW'(1));
          cnt_dec = 1'b1;
        end else begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides both the idle hold and the end-of-word return to IDLE,
    // which is what makes consecutive words gap-free.
    if (accept) begin
      state_d  = SHIFT;
      sout_d   = first_bit(bus.din);
      sh_d     = after_first(bus.din);
      vld_d    = 1'b1;
      last_d   = 1'b0;
      busy_d   = 1'b1;
      cnt_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one instance sends MSB first, one LSB first.
// Every accepted word pushes its expected bit sequence into a per-instance
// queue; each falling edge pops one bit when the queue is non-empty and
// otherwise expects an idle line.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } sbit_t;

  typedef struct {
    int         sel;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mon_en = 1'b0;
  logic       lv [2];
  logic [7:0] dn [2];
  logic [7:0] ex [2];
  logic       acc [2];
  logic       o_s [2];
  logic       o_v [2];
  logic       o_l [2];
  logic       o_b [2];
  logic       o_r [2];

  int         checks   = 0;
  int         failures = 0;

  sbit_t      q [2][$];
  vec_t       vecs [6];

  always #5 clk = ~clk;

  piso_if #(.WIDTH(8)) bus_m ();
  piso_if #(.WIDTH(8)) bus_l ();

  assign bus_m.load_valid = lv[0];
  assign bus_m.din        = dn[0];
  assign bus_l.load_valid = lv[1];
  assign bus_l.din        = dn[1];

  assign o_s[0] = bus_m.sout;
  assign o_v[0] = bus_m.sout_valid;
  assign o_l[0] = bus_m.sout_last;
  assign o_b[0] = bus_m.busy;
  assign o_r[0] = bus_m.load_ready;
  assign o_s[1] = bus_l.sout;
  assign o_v[1] = bus_l.sout_valid;
  assign o_l[1] = bus_l.sout_last;
  assign o_b[1] = bus_l.busy;
  assign o_r[1] = bus_l.load_ready;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  task automatic chk(input string name, input int s, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%b exp=%b t=%0t", name, s, got, exp, $time);
    end
  endtask

  // Monitor and reference model.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      sbit_t e;
      sbit_t t;
      acc[s] = 1'b0;
      if (mon_en) begin
        if (q[s].size() > 0) begin
          e = q[s].pop_front();
          chk("sout_valid", s, o_v[s], 1'b1);
          chk("sout", s, o_s[s], e.b);
          chk("sout_last", s, o_l[s], e.last);
          chk("busy", s, o_b[s], 1'b1);
        end else begin
          chk("idle_sout_valid", s, o_v[s], 1'b0);
          chk("idle_sout", s, o_s[s], 1'b0);
          chk("idle_sout_last", s, o_l[s], 1'b0);
          chk("idle_busy", s, o_b[s], 1'b0);
        end
        if (rst) q[s].delete();
        chk("load_ready", s, o_r[s], !rst && (q[s].size() == 0));
        if (lv[s] && !rst && (q[s].size() == 0)) begin
          acc[s] = 1'b1;
          for (int i = 7; i >= 0; i--) begin
            t.b    = ex[s][i];
            t.last = (i == 0);
            q[s].push_back(t);
          end
        end
      end
    end
  end

  // Offer a word and hold it until the model says it is taken at the next edge.
  task automatic send(input int s, input logic [7:0] d, input logic [7:0] e, input bit hold);
    bit ok;
    ok    = 1'b0;
    lv[s] = 1'b1;
    dn[s] = d;
    ex[s] = e;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      ok = acc[s];
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout dut%0d got=not_accepted exp=accepted din=%h", s, d);
    end
    #1;
    if (!hold) begin
      lv[s] = 1'b0;
      dn[s] = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // exp lists the serial bits in transmit order, leftmost first.
    vecs[0] = '{sel: 0, din: 8'hA5, exp: 8'b10100101};
    vecs[1] = '{sel: 0, din: 8'h3C, exp: 8'b00111100};
    vecs[2] = '{sel: 1, din: 8'h01, exp: 8'b10000000};
    vecs[3] = '{sel: 1, din: 8'h12, exp: 8'b01001000};
    vecs[4] = '{sel: 1, din: 8'hC1, exp: 8'b10000011};
    vecs[5] = '{sel: 0, din: 8'h81, exp: 8'b10000001};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      lv[s] = 1'b0;
      dn[s] = 8'h00;
      ex[s] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].sel, vecs[i].din, vecs[i].exp, 1'b0);
      idle(12);
    end

    // Back-to-back words: din switches right after the first accept.
    send(0, 8'hA5, 8'b10100101, 1'b1);
    send(0, 8'h3C, 8'b00111100, 1'b0);
    idle(12);

    // Word offered while busy must wait for the last-bit cycle.
    send(0, 8'hFF, 8'b11111111, 1'b0);
    idle(1);
    send(0, 8'h00, 8'b00000000, 1'b0);
    idle(12);

    // Reset after three bits of 8'hF0.
    send(0, 8'hF0, 8'b11110000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(12);

    // Reset and load_valid together: word must not be taken.
    rst   = 1'b1;
    lv[0] = 1'b1;
    dn[0] = 8'hAA;
    ex[0] = 8'b10101010;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    lv[0] = 1'b0;
    dn[0] = 8'h00;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on a single serial line. Each bit is qualified by a valid strobe, and the final bit of each word is flagged. It drives the serial side of the storage/latch datapath and feeds downstream bit-level receivers.

Parameters:
WIDTH, 8, word width in bits; must be ≥ 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, synchronous and active-high.
load_valid  input  1  din holds a word to transmit.
load_ready  output  1  serializer can accept a word this cycle.
din  input  WIDTH  parallel word; sampled only on accept.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid bit this cycle.
sout_last  output  1  current sout is the final bit of the word.
busy  output  1  a word is in transmission.

Behaviour:
- Reset (rst=1 at the edge): state←IDLE; sout, sout_valid, sout_last, busy all 0; shift register and counter cleared. load_ready is forced to 0 while rst=1.
- States:
  - IDLE: no word in flight.
  - SHIFT: bits in flight; bit counter cnt ($clog2(WIDTH) bits) holds the number of bits remaining after the current one.
- load_ready (combinational) = !rst && (state==IDLE || (state==SHIFT && cnt==0)).
- Accept: load_valid && load_ready at edge N. At that edge:
  - sout←first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
  - sout_valid←1, busy←1, cnt←WIDTH-1.
  - The remaining bits are loaded into the shift register.
  - state←SHIFT.
- Latency: the first bit is visible in the cycle after the accepting edge. All outputs except load_ready are registered.
- SHIFT, cnt>0: at each edge, sout←next bit from the shift register, cnt←cnt-1, and sout_last←(cnt==1).
- SHIFT, cnt==0 (last bit on sout, sout_last=1):
  - With accept: load the new word as above. The new word's first bit follows the previous last bit with zero bubble cycles.
  - Without accept: state←IDLE; sout_valid, sout_last, busy←0; sout←0.
- load_valid while load_ready=0 is ignored. din is not sampled and no error is raised; the source must hold the word until accepted.
- Exactly WIDTH consecutive sout_valid cycles per accepted word. sout_last is high on exactly one of them, the WIDTH-th.
- Reset mid-word: the remaining bits are discarded. The next cycle shows sout_valid=0 and no partial bits are emitted afterward.
- Simultaneous rst and load_valid: rst wins; the word is not accepted.
- sout is 0 whenever sout_valid=0.

Decomposition:
- Shared package piso_pkg contains:
  - enum state_t {IDLE, SHIFT};
  - localparam function for counter width, $clog2(WIDTH).
- One natural sub-module: piso_bit_counter, a loadable down-counter with a zero flag, synchronous active-high rst on the same clk/rst. The shift register and FSM stay in piso_serializer.

Test Plan:
- WIDTH=8, MSB_FIRST=1; din=8'hA5 pulsed with load_valid for 1 cycle → cycles 1–8 after accept: sout=1,0,1,0,0,1,0,1 with sout_valid=1. sout_last=1 only on cycle 8. busy=1 for 8 cycles, then all outputs 0 and load_ready=1.
- Back-to-back: load_valid held with 8'hA5 then 8'h3C (source switches din on the accept) → 16 contiguous valid bits 10100101 00111100, no gap. load_ready=1 on the cycles where sout_last=1, and 0 on the other busy cycles.
- MSB_FIRST=0, din=8'h01 → sout=1,0,0,0,0,0,0,0; sout_last on the 8th bit.
- Busy ignore: accept 8'hFF, then drive load_valid=1 with din=8'h00 during cycles 2–6 → output stays 11111111. 8'h00 is accepted only in the last-bit cycle and follows immediately as eight zeros.
- Reset mid-word: accept 8'hF0, assert rst after 3 bits (1,1,1) → next cycle sout_valid=0, busy=0, sout=0. No further bits appear; load_ready=1 once rst deasserts.
- Reset with load_valid: rst=1 and load_valid=1 with 8'hAA for 1 cycle → no sout_valid in following cycles. load_ready=0 during rst.
